// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Upstream feeder for the pipelined CPU's instruction memory. A program image
// arrives as a byte stream from the SPART receiver and is written into IMEM one
// 16-bit word at a time. A trailing checksum is verified before the CPU is
// released. The CPU then runs until it reports halt.
//
// Frame on the wire:
//   N[15:8], N[7:0], {w0_hi, w0_lo}, ..., {w(N-1)_hi, w(N-1)_lo}, cksum
//   cksum = XOR of all 2N payload bytes.
//
// Ports
//   clk        in   1   clock
//   rst_n      in   1   asynchronous active-low reset
//   rx_valid   in   1   one-cycle strobe, rx_data holds a received byte
//   rx_data    in   8   received byte
//   abort      in   1   synchronous soft restart, any state -> IDLE
//   cpu_done   in   1   CPU halted
//   imem_wr    out  1   one-cycle IMEM write strobe
//   imem_data  out  16  instruction word being written
//   imem_addr  out  11  word address of the current write
//   cpu_run    out  1   CPU fetch enable
//   load_busy  out  1   a frame is being received (CNT_LO..CKSUM)
//   load_err   out  1   sticky error flag, cleared only by abort or reset
//   err_code   out  2   01 bad count, 10 checksum mismatch, 11 timeout
//   run_done   out  1   one-cycle pulse when a run finishes
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int MAX_WORDS      = 2048,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        abort,
  input  logic        cpu_done,
  output logic        imem_wr,
  output logic [15:0] imem_data,
  output logic [10:0] imem_addr,
  output logic        cpu_run,
  output logic        load_busy,
  output logic        load_err,
  output logic [1:0]  err_code,
  output logic        run_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_LO  = 3'd1,
    WORD_HI = 3'd2,
    WORD_LO = 3'd3,
    CKSUM   = 3'd4,
    RUN     = 3'd5,
    ERR     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_COUNT   = 2'b01,
    ERR_CKSUM   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

  // Word count is judged at full 16 bits so counts like 0x0801 are rejected
  // instead of aliasing onto a legal 11-bit value.
  localparam logic [15:0]     MAX_N   = 16'(MAX_WORDS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [15:0]     word_cnt;   // upper byte first, then the full count N
  logic [7:0]      hi_byte;    // high byte of the word being assembled
  logic [7:0]      acc;        // running XOR of payload bytes
  logic [10:0]     word_idx;   // index of the next word to be written
  logic [TO_W-1:0] to_cnt;     // idle clocks since the last accepted byte

  logic [15:0] count_n;
  logic        count_bad;
  logic        last_word;

  assign count_n   = {word_cnt[15:8], rx_data};
  assign count_bad = (count_n == 16'd0) || (count_n > MAX_N);
  // N is at least 1 whenever this is consulted, so N-1 cannot underflow.
  assign last_word = ({5'd0, word_idx} == (word_cnt - 16'd1));

  // NOTE: every register here is written with <= so all of them update
  // together from the values present before the edge; a blocking = would let
  // later statements see half-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_cnt  <= '0;
      hi_byte   <= '0;
      acc       <= '0;
      word_idx  <= '0;
      to_cnt    <= '0;
      imem_wr   <= 1'b0;
      imem_data <= '0;
      imem_addr <= '0;
      cpu_run   <= 1'b0;
      load_busy <= 1'b0;
      load_err  <= 1'b0;
      err_code  <= ERR_NONE;
      run_done  <= 1'b0;
    end else begin
      // Strobes default low each cycle so they can only ever last one clock.
      imem_wr  <= 1'b0;
      run_done <= 1'b0;

      if (abort) begin
        // Abort outranks rx_valid and cpu_done; because imem_wr was already
        // defaulted low above, a write that this edge would have issued is
        // dropped.
        state     <= IDLE;
        word_cnt  <= '0;
        hi_byte   <= '0;
        acc       <= '0;
        word_idx  <= '0;
        to_cnt    <= '0;
        cpu_run   <= 1'b0;
        load_busy <= 1'b0;
        load_err  <= 1'b0;
        err_code  <= ERR_NONE;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid) begin
              word_cnt  <= {rx_data, 8'h00};
              to_cnt    <= '0;
              load_busy <= 1'b1;
              state     <= CNT_LO;
            end
          end

          CNT_LO, WORD_HI, WORD_LO, CKSUM: begin
            if (!rx_valid) begin
              if (to_cnt == TO_LAST) begin
                load_busy <= 1'b0;
                load_err  <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= ERR;
              end else begin
                to_cnt <= to_cnt + 1'b1;
              end
            end else begin
              to_cnt <= '0;
              case (state)
                CNT_LO: begin
                  word_cnt <= count_n;
                  if (count_bad) begin
                    load_busy <= 1'b0;
                    load_err  <= 1'b1;
                    err_code  <= ERR_COUNT;
                    state     <= ERR;
                  end else begin
                    word_idx <= '0;
                    acc      <= '0;
                    state    <= WORD_HI;
                  end
                end

                WORD_HI: begin
                  hi_byte <= rx_data;
                  acc     <= acc ^ rx_data;
                  state   <= WORD_LO;
                end

                WORD_LO: begin
                  acc       <= acc ^ rx_data;
                  imem_wr   <= 1'b1;
                  imem_data <= {hi_byte, rx_data};
                  imem_addr <= word_idx;
                  if (last_word) begin
                    state <= CKSUM;
                  end else begin
                    // Only advance when more words follow, so the index never
                    // wraps even for a full MAX_WORDS image.
                    word_idx <= word_idx + 1'b1;
                    state    <= WORD_HI;
                  end
                end

                CKSUM: begin
                  load_busy <= 1'b0;
                  if (rx_data == acc) begin
                    cpu_run <= 1'b1;
                    state   <= RUN;
                  end else begin
                    load_err <= 1'b1;
                    err_code <= ERR_CKSUM;
                    state    <= ERR;
                  end
                end

                default: ;
              endcase
            end
          end

          RUN: begin
            // Received bytes are ignored while the CPU owns IMEM.
            if (cpu_done) begin
              cpu_run  <= 1'b0;
              run_done <= 1'b1;
              state    <= IDLE;
            end
          end

          ERR: ;  // hold load_err and err_code until abort or reset

          default: begin
            state     <= IDLE;
            load_busy <= 1'b0;
            cpu_run   <= 1'b0;
          end
        endcase
      end
    end
  end

  // The CPU must never fetch while IMEM is being written, and loading and
  // running are mutually exclusive.
  a_no_wr_while_run : assert property (
    @(posedge clk) disable iff (!rst_n) !(imem_wr && cpu_run));
  a_busy_run_excl : assert property (
    @(posedge clk) disable iff (!rst_n) !(load_busy && cpu_run));

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Bench for imem_loader. Frames are generated as byte lists; a reference model
// parses each list from the frame rules (count, payload words, XOR checksum)
// to predict the IMEM writes and the final outcome. A monitor collects every
// write seen on the IMEM port. The timeout is shortened to 16 clocks.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int MAX_WORDS      = 2048;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int TO_W           = 20;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        abort    = 1'b0;
  logic        cpu_done = 1'b0;
  logic        imem_wr;
  logic [15:0] imem_data;
  logic [10:0] imem_addr;
  logic        cpu_run;
  logic        load_busy;
  logic        load_err;
  logic [1:0]  err_code;
  logic        run_done;

  int checks = 0;
  int errors = 0;

  logic [26:0] wr_q[$];     // observed writes {addr, data}
  logic [26:0] exp_q[$];    // predicted writes {addr, data}
  logic [7:0]  byte_q[$];   // frame being sent

  always #5 clk = ~clk;

  imem_loader #(
    .MAX_WORDS      (MAX_WORDS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .abort     (abort),
    .cpu_done  (cpu_done),
    .imem_wr   (imem_wr),
    .imem_data (imem_data),
    .imem_addr (imem_addr),
    .cpu_run   (cpu_run),
    .load_busy (load_busy),
    .load_err  (load_err),
    .err_code  (err_code),
    .run_done  (run_done)
  );

  // Write monitor: records every write and checks the CPU is parked meanwhile.
  always @(negedge clk) begin
    if (rst_n && imem_wr === 1'b1) begin
      wr_q.push_back({imem_addr, imem_data});
      checks++;
      if (cpu_run !== 1'b0) begin
        errors++;
        $display("FAIL wr_while_run: cpu_run=%b during imem_wr, required 0", cpu_run);
      end
    end
  end

  // Observed flags packed as {busy, run, err, code[1:0], done, wr}.
  function automatic logic [6:0] flags();
    return {load_busy, cpu_run, load_err, err_code, run_done, imem_wr};
  endfunction

  function automatic logic [6:0] mk(logic b, logic r, logic e, logic [1:0] c,
                                    logic d, logic w);
    return {b, r, e, c, d, w};
  endfunction

  // Present one byte for exactly one rising edge; called and returns at a negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // Build a frame of n words; a corrupted frame gets a wrong checksum byte.
  task automatic build_frame(input int n, input bit corrupt);
    logic [15:0] nn;
    logic [7:0]  x;
    logic [7:0]  b;
    nn = 16'(n);
    byte_q.delete();
    byte_q.push_back(nn[15:8]);
    byte_q.push_back(nn[7:0]);
    if (n >= 1 && n <= MAX_WORDS) begin
      x = 8'h00;
      for (int i = 0; i < 2 * n; i++) begin
        b = 8'($urandom);
        byte_q.push_back(b);
        x = x ^ b;
      end
      byte_q.push_back(corrupt ? (x ^ 8'($urandom_range(255, 1))) : x);
    end
  endtask

  // Reference model: parse byte_q by the frame rules. code 0 = run,
  // 1 = bad count, 2 = checksum mismatch.
  task automatic model_frame(output logic [1:0] code);
    int          n;
    logic [7:0]  x;
    exp_q.delete();
    n = int'({byte_q[0], byte_q[1]});
    if (n == 0 || n > MAX_WORDS) begin
      code = 2'b01;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({11'(i), byte_q[2 + 2 * i], byte_q[3 + 2 * i]});
      x = x ^ byte_q[2 + 2 * i] ^ byte_q[3 + 2 * i];
    end
    code = (byte_q[2 + 2 * n] == x) ? 2'b00 : 2'b10;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++;
    if ({flags(), imem_data, imem_addr} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {flags(), imem_data, imem_addr});
    end
    rst_n = 1'b1;
    idle(40);  // IDLE never times out
    checks++;
    if (flags() !== 7'd0) begin
      errors++;
      $display("FAIL reset_idle: flags=%b required 0000000", flags());
    end
  endtask

  task automatic test_t1();
    wr_q.delete();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    checks++;
    if ({imem_wr, imem_addr, imem_data} !== {1'b1, 11'd0, 16'h1234}) begin
      errors++;
      $display("FAIL t1_word0: wr=%b addr=%0d data=%h required 1/0/1234",
               imem_wr, imem_addr, imem_data);
    end
    send_byte(8'hAB); send_byte(8'hCD);
    checks++;
    if ({imem_wr, imem_addr, imem_data} !== {1'b1, 11'd1, 16'hABCD}) begin
      errors++;
      $display("FAIL t1_word1: wr=%b addr=%0d data=%h required 1/1/abcd",
               imem_wr, imem_addr, imem_data);
    end
    send_byte(8'h40);
    checks++;
    if (flags() !== mk(0, 1, 0, 2'b00, 0, 0)) begin
      errors++;
      $display("FAIL t1_run: flags=%b required %b", flags(), mk(0, 1, 0, 2'b00, 0, 0));
    end
    checks++;
    if (wr_q.size() != 2) begin
      errors++;
      $display("FAIL t1_wr_count: got %0d required 2", wr_q.size());
    end
    // T5: halt the CPU.
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
    checks++;
    if (flags() !== mk(0, 0, 0, 2'b00, 1, 0)) begin
      errors++;
      $display("FAIL t5_done: flags=%b required %b", flags(), mk(0, 0, 0, 2'b00, 1, 0));
    end
    @(negedge clk);
    checks++;
    if (flags() !== 7'd0) begin
      errors++;
      $display("FAIL t5_done_pulse: flags=%b required 0000000", flags());
    end
  endtask

  task automatic test_t2_bad_cksum();
    wr_q.delete();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h41);
    checks++;
    if (flags() !== mk(0, 0, 1, 2'b10, 0, 0)) begin
      errors++;
      $display("FAIL t2_err: flags=%b required %b", flags(), mk(0, 0, 1, 2'b10, 0, 0));
    end
    checks++;
    if (wr_q.size() != 2) begin
      errors++;
      $display("FAIL t2_wr_count: got %0d required 2", wr_q.size());
    end
    pulse_abort();
  endtask

  task automatic test_bad_count();
    logic [15:0] bad[2];
    bad[0] = 16'h0000;
    bad[1] = 16'h0801;
    for (int k = 0; k < 2; k++) begin
      wr_q.delete();
      send_byte(bad[k][15:8]);
      send_byte(bad[k][7:0]);
      checks++;
      if (flags() !== mk(0, 0, 1, 2'b01, 0, 0)) begin
        errors++;
        $display("FAIL count_err_%0d: flags=%b required %b", k, flags(), mk(0, 0, 1, 2'b01, 0, 0));
      end
      // ERR ignores further bytes.
      for (int j = 0; j < 4; j++) send_byte(8'($urandom));
      idle(20);
      checks++;
      if (flags() !== mk(0, 0, 1, 2'b01, 0, 0) || wr_q.size() != 0) begin
        errors++;
        $display("FAIL count_hold_%0d: flags=%b writes=%0d required %b and 0",
                 k, flags(), wr_q.size(), mk(0, 0, 1, 2'b01, 0, 0));
      end
      pulse_abort();
      checks++;
      if (flags() !== 7'd0) begin
        errors++;
        $display("FAIL count_abort_%0d: flags=%b required 0000000", k, flags());
      end
    end
    // N == MAX_WORDS is the largest legal count.
    send_byte(8'h08);
    send_byte(8'h00);
    checks++;
    if (flags() !== mk(1, 0, 0, 2'b00, 0, 0)) begin
      errors++;
      $display("FAIL count_max_ok: flags=%b required %b", flags(), mk(1, 0, 0, 2'b00, 0, 0));
    end
    pulse_abort();
  endtask

  task automatic test_timeout();
    wr_q.delete();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    idle(TIMEOUT_CYCLES - 1);
    checks++;
    if (flags() !== mk(1, 0, 0, 2'b00, 0, 0)) begin
      errors++;
      $display("FAIL timeout_early: flags=%b required %b", flags(), mk(1, 0, 0, 2'b00, 0, 0));
    end
    idle(1);
    checks++;
    if (flags() !== mk(0, 0, 1, 2'b11, 0, 0)) begin
      errors++;
      $display("FAIL timeout_err: flags=%b required %b", flags(), mk(0, 0, 1, 2'b11, 0, 0));
    end
    send_byte(8'h34);  // late byte
    idle(2);
    checks++;
    if (flags() !== mk(0, 0, 1, 2'b11, 0, 0) || wr_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_late: flags=%b writes=%0d required %b and 0",
               flags(), wr_q.size(), mk(0, 0, 1, 2'b11, 0, 0));
    end
    pulse_abort();
  endtask

  task automatic test_abort();
    // Abort together with the low byte of word 1: that write must not happen.
    wr_q.delete();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33);
    abort    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    @(negedge clk);
    abort    = 1'b0;
    rx_valid = 1'b0;
    idle(2);
    checks++;
    if (flags() !== 7'd0 || wr_q.size() != 1) begin
      errors++;
      $display("FAIL abort_vs_rx: flags=%b writes=%0d required 0000000 and 1",
               flags(), wr_q.size());
    end
    // Abort together with cpu_done while running: no run_done pulse.
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h66);
    checks++;
    if (cpu_run !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup_run: cpu_run=%b required 1", cpu_run);
    end
    abort    = 1'b1;
    cpu_done = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    cpu_done = 1'b0;
    checks++;
    if (flags() !== 7'd0) begin
      errors++;
      $display("FAIL abort_vs_done: flags=%b required 0000000", flags());
    end
  endtask

  task automatic test_reset_mid_load();
    wr_q.delete();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);  // now in WORD_LO
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({flags(), imem_data, imem_addr} !== 34'd0) begin
      errors++;
      $display("FAIL t6_async: got %h required 0", {flags(), imem_data, imem_addr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h34);  // taken as a new count high byte, not a word
    idle(3);
    checks++;
    if (wr_q.size() != 0 || flags() !== mk(1, 0, 0, 2'b00, 0, 0)) begin
      errors++;
      $display("FAIL t6_no_write: writes=%0d flags=%b required 0 and %b",
               wr_q.size(), flags(), mk(1, 0, 0, 2'b00, 0, 0));
    end
    pulse_abort();
  endtask

  task automatic test_random_frames();
    int          sel;
    int          n;
    bit          corrupt;
    logic [1:0]  code;
    logic [6:0]  want;
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(99, 0);
      if (sel < 4)       n = 0;
      else if (sel < 12) n = $urandom_range(65535, MAX_WORDS + 1);
      else if (sel < 30) n = $urandom_range(40, 9);
      else               n = $urandom_range(6, 1);
      corrupt = ($urandom_range(99, 0) < 30);
      build_frame(n, corrupt);
      model_frame(code);
      wr_q.delete();
      foreach (byte_q[i]) begin
        send_byte(byte_q[i]);
        if (i != byte_q.size() - 1) idle($urandom_range(3, 0));
      end

      checks++;
      if (wr_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_wr_count: got %0d required %0d", it, wr_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (wr_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand%0d_wr%0d: addr/data got %h required %h", it, i, wr_q[i], exp_q[i]);
          end
        end
      end

      want = (code == 2'b00) ? mk(0, 1, 0, 2'b00, 0, 0) : mk(0, 0, 1, code, 0, 0);
      checks++;
      if (flags() !== want) begin
        errors++;
        $display("FAIL rand%0d_end: flags=%b required %b", it, flags(), want);
      end

      if (code == 2'b00) begin
        send_byte(8'($urandom));  // ignored in RUN
        idle(1);
        checks++;
        if (flags() !== want || wr_q.size() != exp_q.size()) begin
          errors++;
          $display("FAIL rand%0d_run_ignore: flags=%b writes=%0d required %b and %0d",
                   it, flags(), wr_q.size(), want, exp_q.size());
        end
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
        checks++;
        if (flags() !== mk(0, 0, 0, 2'b00, 1, 0)) begin
          errors++;
          $display("FAIL rand%0d_done: flags=%b required %b", it, flags(), mk(0, 0, 0, 2'b00, 1, 0));
        end
        @(negedge clk);
      end else begin
        pulse_abort();
        checks++;
        if (flags() !== 7'd0) begin
          errors++;
          $display("FAIL rand%0d_abort: flags=%b required 0000000", it, flags());
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_t1();
    test_t2_bad_cksum();
    test_bad_count();
    test_timeout();
    test_abort();
    test_reset_mid_load();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
